// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch PC unit.
//   RESET_VEC_DEFAULT / EXC_VEC_DEFAULT : default reset and exception vectors
//   redirect_src_e                      : which source drives the next PC
//   jump_target()                       : J/JAL target from the Decode PC and the jump index
package pc_pkg;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEFAULT   = 32'h0000_4180;

  // Listed in decreasing priority order.
  typedef enum logic [2:0] {
    EXC,
    ERET,
    HOLD,
    JR,
    JUMP,
    BR,
    SEQ
  } redirect_src_e;

  // The region bits come from pc_D+4, so a jump in the last slot of a
  // 256 MB region lands in the next region.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_dec,
                                              input logic [25:0] index);
    logic [31:0] pc_plus4;
    pc_plus4 = pc_dec + 32'd4;
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, rst_n   : clock, asynchronous active-low reset (clears count/pointer only)
//   push_i       : push push_data_i
//   pop_i        : pop the top entry (no-op when empty)
//   push_data_i  : return address to push
//   top_o        : top entry, 0 when empty
//   valid_o      : stack non-empty
// A push to a full stack overwrites the oldest entry; push and pop together
// replace the top entry (or create one if the stack was empty).
module pc_ras #(
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] push_data_i,
  output logic [31:0] top_o,
  output logic        valid_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;     // next free slot; top is ptr_q-1
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] top_idx;
  logic          wr_en;
  logic [PW-1:0] wr_idx;

  assign top_idx = ptr_q - PW'(1);
  assign valid_o = (cnt_q != '0);
  assign top_o   = valid_o ? mem_q[top_idx] : 32'h0;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_i && pop_i) begin
      wr_en = 1'b1;
      if (cnt_q == '0) begin
        wr_idx = ptr_q;
        ptr_d  = ptr_q + PW'(1);
        cnt_d  = CW'(1);
      end else begin
        wr_idx = top_idx;
      end
    end else if (push_i) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      ptr_d  = ptr_q + PW'(1);
      if (cnt_q != CW'(RAS_DEPTH)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage is never reset; reads are masked by the count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with next-PC selection and return-address
// prediction.
//   clk, rst_n            : clock, asynchronous active-low reset
//   stall                 : hold PC and freeze the RAS
//   pc_D, ins_D, imm_D    : Decode-stage PC, instruction, sign-extended offset
//   rdata1_D              : forwarded rs value (jr target)
//   br_taken_D, j_D, jal_D, jr_D, jr_ra_D : resolved control flow in Decode
//   exc_req, eret_D, epc  : exception redirect / return
//   pc_F, pc4_F           : fetch PC and fetch PC + 4
//   misalign_F            : fetch PC not word aligned
//   ras_valid, ras_top    : RAS non-empty / predicted return address
//   ras_mispred           : registered pulse, jr $31 target differed from the prediction
//   mispred_cnt           : saturating count of those pulses
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEFAULT,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] pc_D,
  input  logic [31:0] ins_D,
  input  logic [31:0] imm_D,
  input  logic [31:0] rdata1_D,
  input  logic        br_taken_D,
  input  logic        j_D,
  input  logic        jal_D,
  input  logic        jr_D,
  input  logic        jr_ra_D,
  input  logic        exc_req,
  input  logic        eret_D,
  input  logic [31:0] epc,
  output logic [31:0] pc_F,
  output logic [31:0] pc4_F,
  output logic        misalign_F,
  output logic        ras_valid,
  output logic [31:0] ras_top,
  output logic        ras_mispred,
  output logic [15:0] mispred_cnt
);

  logic [31:0]   pc_q, pc_d;
  logic          mispred_q, mispred_d;
  logic [15:0]   mispred_cnt_q, mispred_cnt_d;
  redirect_src_e src;
  logic          accepted;
  logic          ras_push, ras_pop;
  logic          unused_ins_hi;

  assign unused_ins_hi = ^ins_D[31:26];

  assign pc_F        = pc_q;
  assign pc4_F       = pc_q + 32'd4;
  assign misalign_F  = |pc_q[1:0];
  assign ras_mispred = mispred_q;
  assign mispred_cnt = mispred_cnt_q;

  // eret also redirects away from the Decode instruction, so it must not
  // touch the stack either.
  assign accepted = !stall && !exc_req && !eret_D;
  assign ras_push = accepted && jal_D;
  assign ras_pop  = accepted && jr_D && jr_ra_D;

  always_comb begin
    if (exc_req)           src = EXC;
    else if (eret_D)       src = ERET;
    else if (stall)        src = HOLD;
    else if (jr_D)         src = JR;
    else if (j_D || jal_D) src = JUMP;
    else if (br_taken_D)   src = BR;
    else                   src = SEQ;
  end

  always_comb begin
    case (src)
      EXC:     pc_d = EXC_VEC;
      ERET:    pc_d = epc;
      HOLD:    pc_d = pc_q;
      JR:      pc_d = rdata1_D;
      JUMP:    pc_d = jump_target(pc_D, ins_D[25:0]);
      BR:      pc_d = pc_D + 32'd4 + {imm_D[29:0], 2'b00};
      default: pc_d = pc_q + 32'd4;
    endcase
  end

  // Prediction is judged against the stack state before this cycle's pop.
  assign mispred_d     = ras_pop && (!ras_valid || (ras_top != rdata1_D));
  assign mispred_cnt_d = (mispred_d && (mispred_cnt_q != 16'hFFFF))
                         ? mispred_cnt_q + 16'd1 : mispred_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_VEC;
      mispred_q     <= 1'b0;
      mispred_cnt_q <= 16'h0;
    end else begin
      pc_q          <= pc_d;
      mispred_q     <= mispred_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  pc_ras #(
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .push_data_i(pc_D + 32'd8),
    .top_o      (ras_top),
    .valid_o    (ras_valid)
  );

endmodule
